// File: rtl/can_id_arbiter_pkg.sv
// can_pkg: shared types and constants for the CAN identifier-field engine.
//   can_state_e   : arbiter FSM state encoding (also used on the debug port)
//   CAN_BASE_W    : base identifier width of a CAN 2.0A identifier
//   CAN_EXT_W     : extension identifier width of a CAN 2.0B identifier
//   CAN_DOMINANT  : bus level 0
//   CAN_RECESSIVE : bus level 1
//   std_len()     : bit count of a standard arbitration field (base, RTR, IDE)
//   ext_len()     : bit count of an extended arbitration field
//                   (base, SRR, IDE, ext, RTR)
package can_pkg;

  typedef enum logic [1:0] {
    CAN_IDLE  = 2'd0,
    CAN_READY = 2'd1,
    CAN_SHIFT = 2'd2,
    CAN_LOST  = 2'd3
  } can_state_e;

  localparam int   CAN_BASE_W    = 11;
  localparam int   CAN_EXT_W     = 18;
  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  function automatic int std_len(input int base_w);
    return base_w + 2;
  endfunction

  function automatic int ext_len(input int base_w, input int ext_w);
    return base_w + ext_w + 3;
  endfunction

endpackage

// File: rtl/can_id_arbiter_if.sv
// can_id_arbiter_if: bus between the frame maker and the identifier-field
// engine.
//   master modport (frame maker / bench): drives sp, load, idf, idf_ex, ide,
//     rtr, start, rx_bit; observes tx_bit, busy, done, arb_lost, idtfr and
//     state_dbg.
//   slave modport (can_id_arbiter): the reverse.
// Handshake: load is sampled only while the engine is idle and start only
// while it is ready; both are single-clk level strobes with no ready return,
// busy tells the master when a new load would be ignored. sp is a one-clk
// strobe marking the sample point; rx_bit is valid in the same clk as sp.
interface can_id_arbiter_if #(
  parameter int BASE_W = 11,
  parameter int EXT_W  = 18
);
  logic                      sp;
  logic                      load;
  logic [BASE_W-1:0]         idf;
  logic [EXT_W-1:0]          idf_ex;
  logic                      ide;
  logic                      rtr;
  logic                      start;
  logic                      rx_bit;
  logic                      tx_bit;
  logic                      busy;
  logic                      done;
  logic                      arb_lost;
  logic [BASE_W+EXT_W-1:0]   idtfr;
  logic [1:0]                state_dbg;

  modport master (
    output sp, load, idf, idf_ex, ide, rtr, start, rx_bit,
    input  tx_bit, busy, done, arb_lost, idtfr, state_dbg
  );

  modport slave (
    input  sp, load, idf, idf_ex, ide, rtr, start, rx_bit,
    output tx_bit, busy, done, arb_lost, idtfr, state_dbg
  );
endinterface

// File: rtl/can_id_arbiter_rx_capture.sv
// can_id_rx_capture: receive side of the identifier field.
// Collects the bus bits sampled at each sp into a base and an extension shift
// register, remembers the received IDE bit, and publishes the identifier on
// idtfr at the end of the field. When the received IDE is dominant the upper
// (extension) part of idtfr is written with zeros.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   cap        : capture rx_bit this clk (sp while a field is in progress)
//   fin        : this capture is the last bit of the field
//   idx        : position of the captured bit within the arbitration field
//   rx_bit     : sampled bus level
//   rx_ide     : received IDE bit (valid once index BASE_W+1 was captured)
//   idtfr      : {ext, base} of the last completed field
module can_id_rx_capture #(
  parameter int BASE_W = 11,
  parameter int EXT_W  = 18,
  parameter int CNT_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cap,
  input  logic                    fin,
  input  logic [CNT_W-1:0]        idx,
  input  logic                    rx_bit,
  output logic                    rx_ide,
  output logic [BASE_W+EXT_W-1:0] idtfr
);

  // Field positions: base occupies [0, BASE_W-1], then SRR/RTR, then IDE,
  // then the extension, then the extended-frame RTR.
  localparam logic [CNT_W-1:0] IDX_SRR  = CNT_W'(BASE_W);
  localparam logic [CNT_W-1:0] IDX_IDE  = CNT_W'(BASE_W + 1);
  localparam logic [CNT_W-1:0] IDX_EXT0 = CNT_W'(BASE_W + 2);
  localparam logic [CNT_W-1:0] IDX_EXTN = CNT_W'(BASE_W + EXT_W + 1);

  logic [BASE_W-1:0] base_sr;
  logic [EXT_W-1:0]  ext_sr;
  logic              ide_now;

  // A standard field ends on its IDE bit, so the IDE value deciding the
  // zero-fill may be the bit being captured right now.
  always_comb begin
    ide_now = (idx == IDX_IDE) ? rx_bit : rx_ide;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_sr <= '0;
      ext_sr  <= '0;
      rx_ide  <= 1'b0;
      idtfr   <= '0;
    end else if (cap) begin
      if (idx < IDX_SRR) begin
        base_sr <= {base_sr[BASE_W-2:0], rx_bit};
      end
      if (idx == IDX_IDE) begin
        rx_ide <= rx_bit;
      end
      if ((idx >= IDX_EXT0) && (idx <= IDX_EXTN)) begin
        ext_sr <= {ext_sr[EXT_W-2:0], rx_bit};
      end
      // The final bit is never a base or extension bit, so both shift
      // registers are already complete here.
      if (fin) begin
        idtfr <= ide_now ? {ext_sr, base_sr} : {{EXT_W{1'b0}}, base_sr};
      end
    end
  end

endmodule

// File: rtl/can_id_arbiter.sv
// can_id_arbiter: identifier-field engine of the CAN frame maker.
// Latches a pending base/extended identifier, serialises the arbitration
// field MSB-first (one bit per sp), watches the bus for arbitration loss and
// rebuilds the identifier seen on the bus.
// Build option: define CAN_ID_ARB_LOSS_EN to enable loss detection and the
// LOST state. Without it the block never backs off (single-node loopback):
// arb_lost stays 0 and every started field ends with done.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   bus (slave)    : sp, load, idf, idf_ex, ide, rtr, start, rx_bit in;
//                    tx_bit, busy, done, arb_lost, idtfr, state_dbg out
module can_id_arbiter
  import can_pkg::*;
#(
  parameter int BASE_W = CAN_BASE_W,
  parameter int EXT_W  = CAN_EXT_W,
  parameter int CNT_W  = 6
) (
  input  logic            clk,
  input  logic            reset,
  can_id_arbiter_if.slave bus
);

  localparam int TX_W = ext_len(BASE_W, EXT_W);
  localparam logic [CNT_W-1:0] STD_LAST = CNT_W'(std_len(BASE_W) - 1);
  localparam logic [CNT_W-1:0] EXT_LAST = CNT_W'(ext_len(BASE_W, EXT_W) - 1);

  localparam logic [1:0] S_IDLE  = CAN_IDLE;
  localparam logic [1:0] S_READY = CAN_READY;
  localparam logic [1:0] S_SHIFT = CAN_SHIFT;
  localparam logic [1:0] S_LOST  = CAN_LOST;

  logic [1:0]       state;
  logic [TX_W-1:0]  tx_sr;     // remaining bits, next one at the MSB
  logic [CNT_W-1:0] last_q;    // index of the final bit of our own field
  logic [CNT_W-1:0] cnt;       // index of the bit currently on the bus
  logic             tx_q;
  logic             done_q;
  logic             lost_q;

  logic [TX_W-1:0]  std_img;
  logic [TX_W-1:0]  ext_img;
  logic             loss;
  logic             tx_last;
  logic             rx_last;
  logic             cap;
  logic             fin;
  logic             rx_ide;

  // Left-aligned transmit images; the unused tail of a standard field is
  // never shifted out.
  always_comb begin
    std_img = {bus.idf, bus.rtr, CAN_DOMINANT, {(EXT_W + 1){1'b0}}};
    ext_img = {bus.idf, CAN_RECESSIVE, CAN_RECESSIVE, bus.idf_ex, bus.rtr};
  end

  always_comb begin
`ifdef CAN_ID_ARB_LOSS_EN
    // Recessive sent, dominant seen. The IDE bit of a standard field lies
    // outside the window (it is sent dominant anyway).
    loss = ((last_q == EXT_LAST) || (cnt != STD_LAST)) &&
           (tx_q == CAN_RECESSIVE) && (bus.rx_bit == CAN_DOMINANT);
`else
    loss = 1'b0;
`endif
    tx_last = (cnt == last_q);
    // End of the field as seen on the bus: a dominant IDE ends a standard
    // field, a recessive IDE captured earlier means the extended length.
    rx_last = ((cnt == STD_LAST) && (bus.rx_bit == CAN_DOMINANT)) ||
              ((cnt == EXT_LAST) && rx_ide);
    cap = bus.sp && ((state == S_SHIFT) || (state == S_LOST));
    fin = 1'b0;
    if (cap) begin
      fin = (state == S_SHIFT) ? (loss ? rx_last : tx_last) : rx_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      tx_sr  <= '0;
      last_q <= '0;
      cnt    <= '0;
      tx_q   <= CAN_RECESSIVE;
      done_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lost_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            tx_sr  <= bus.ide ? ext_img : std_img;
            last_q <= bus.ide ? EXT_LAST : STD_LAST;
            state  <= S_READY;
          end
        end
        S_READY: begin
          // start outranks a coincident sp: bit 0 gets a full sp period.
          if (bus.start) begin
            tx_q  <= tx_sr[TX_W-1];
            tx_sr <= tx_sr << 1;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bus.sp) begin
            if (loss) begin
              lost_q <= 1'b1;
              tx_q   <= CAN_RECESSIVE;
              if (rx_last) begin
                cnt   <= '0;
                state <= S_IDLE;
              end else begin
                cnt   <= cnt + 1'b1;
                state <= S_LOST;
              end
            end else if (tx_last) begin
              done_q <= 1'b1;
              tx_q   <= CAN_RECESSIVE;
              cnt    <= '0;
              state  <= S_IDLE;
            end else begin
              tx_q  <= tx_sr[TX_W-1];
              tx_sr <= tx_sr << 1;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        S_LOST: begin
          if (bus.sp) begin
            if (rx_last) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  can_id_rx_capture #(
    .BASE_W (BASE_W),
    .EXT_W  (EXT_W),
    .CNT_W  (CNT_W)
  ) u_rx_capture (
    .clk    (clk),
    .reset  (reset),
    .cap    (cap),
    .fin    (fin),
    .idx    (cnt),
    .rx_bit (bus.rx_bit),
    .rx_ide (rx_ide),
    .idtfr  (bus.idtfr)
  );

  assign bus.tx_bit    = tx_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.arb_lost  = lost_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_can_id_arbiter.sv
// tb_can_id_arbiter: self-checking bench for can_id_arbiter.
// A driver plays our node plus an optional competing node on a wired-AND
// bus; a reference model derives the bit sequences, the winner and the
// expected end-of-field result, which a monitor checks against done/arb_lost.
module tb_can_id_arbiter;
  import can_pkg::*;

  localparam int BASE_W = 11;
  localparam int EXT_W  = 18;
  localparam int CNT_W  = 6;
  localparam int ID_W   = BASE_W + EXT_W;
  localparam int OBS_W  = ID_W + 2;
`ifdef CAN_ID_ARB_LOSS_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic [EXT_W-1:0]  ext;
    logic              ide;
    logic              rtr;
  } frame_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  can_id_arbiter_if #(.BASE_W(BASE_W), .EXT_W(EXT_W)) bus ();

  can_id_arbiter #(
    .BASE_W (BASE_W),
    .EXT_W  (EXT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [OBS_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic frame_t mk(input logic [BASE_W-1:0] b, input logic [EXT_W-1:0] e,
                                input logic i, input logic r);
    frame_t f;
    f.base = b; f.ext = e; f.ide = i; f.rtr = r;
    return f;
  endfunction

  // Arbitration field as sent, bit 0 first.
  function automatic void build_seq(input frame_t f, output logic [31:0] b, output int n);
    b = '0;
    n = 0;
    for (int j = BASE_W - 1; j >= 0; j--) begin b[n] = f.base[j]; n++; end
    if (!f.ide) begin
      b[n] = f.rtr; n++;
      b[n] = 1'b0;  n++;
    end else begin
      b[n] = 1'b1; n++;
      b[n] = 1'b1; n++;
      for (int j = EXT_W - 1; j >= 0; j--) begin b[n] = f.ext[j]; n++; end
      b[n] = f.rtr; n++;
    end
  endfunction

  function automatic logic [ID_W-1:0] frame_id(input frame_t f);
    return f.ide ? {f.ext, f.base} : {{EXT_W{1'b0}}, f.base};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [OBS_W-1:0] obs;
    logic [OBS_W-1:0] exp;
    if (reset !== 1'b1 && (bus.done === 1'b1 || bus.arb_lost === 1'b1)) begin
      obs = {bus.done, bus.arb_lost, bus.idtfr};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", obs);
      end else begin
        exp = exp_q.pop_front();
        check("frame_result", obs, exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic scramble_inputs();
    bus.idf    = BASE_W'($urandom);
    bus.idf_ex = EXT_W'($urandom);
    bus.ide    = 1'($urandom);
    bus.rtr    = 1'($urandom);
  endtask

  task automatic run_frame(input frame_t me, input bit has_other, input frame_t other,
                           input bit start_with_sp, input bit load_mid, input int abort_at,
                           input string tag);
    logic [31:0]     s, o, bus_seq;
    int              ns, no, nb, k;
    bit              lose, lost_ev;
    logic [ID_W-1:0] win_id;
    logic            exp_tx;
    build_seq(me, s, ns);
    lose = 1'b0; k = ns; bus_seq = s; nb = ns; win_id = frame_id(me);
    if (has_other) begin
      build_seq(other, o, no);
      for (int i = 0; i < ns && i < no; i++) begin
        if (s[i] != o[i]) begin
          if (o[i] == 1'b0) begin
            lose = 1'b1; k = i; bus_seq = o; nb = no; win_id = frame_id(other);
          end
          break;
        end
      end
    end
    lost_ev = LOSS_EN && lose;
    if (abort_at < 0) exp_q.push_back({!lost_ev, lost_ev, win_id});

    bus.idf = me.base; bus.idf_ex = me.ext; bus.ide = me.ide; bus.rtr = me.rtr;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    scramble_inputs();
    check({tag, "_ready"}, bus.state_dbg, CAN_READY);
    bus.start = 1'b1;
    bus.sp    = start_with_sp;
    tick();
    bus.start = 1'b0;
    bus.sp    = 1'b0;
    check({tag, "_shift"}, bus.state_dbg, CAN_SHIFT);

    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == abort_at) begin
        do_reset(1);
        check({tag, "_rst_state"}, bus.state_dbg, CAN_IDLE);
        check({tag, "_rst_tx"}, bus.tx_bit, 1'b1);
        check({tag, "_rst_busy"}, bus.busy, 1'b0);
        check({tag, "_rst_idtfr"}, bus.idtfr, '0);
        return;
      end
      if (load_mid && i == 3) begin
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
      end
      exp_tx = (lost_ev && i > k) ? 1'b1 : s[i];
      check($sformatf("%s_tx%0d", tag, i), bus.tx_bit, exp_tx);
      bus.rx_bit = bus_seq[i];
      bus.sp     = 1'b1;
      tick();
      bus.sp     = 1'b0;
      bus.rx_bit = 1'b1;
    end
    tick();
    tick();
    check({tag, "_end_busy"}, bus.busy, 1'b0);
    check({tag, "_end_tx"}, bus.tx_bit, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    frame_t me, other, none;
    none = mk('0, '0, 1'b0, 1'b0);
    bus.sp = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.rx_bit = 1'b1;
    scramble_inputs();
    do_reset(3);

    check("reset_state", bus.state_dbg, CAN_IDLE);
    check("reset_tx", bus.tx_bit, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_lost", bus.arb_lost, 1'b0);
    check("reset_idtfr", bus.idtfr, '0);

    run_frame(mk(11'h123, '0, 1'b0, 1'b0), 1'b0, none, 1'b0, 1'b0, -1, "std");
    run_frame(mk(11'h7FF, 18'h2AAAA, 1'b1, 1'b1), 1'b0, none, 1'b0, 1'b0, -1, "ext");
    run_frame(mk(11'h400, '0, 1'b0, 1'b0), 1'b1, mk(11'h3FF, '0, 1'b0, 1'b0),
              1'b0, 1'b0, -1, "loss");

    // start and sp while idle must be ignored
    bus.start = 1'b1; bus.sp = 1'b1;
    tick();
    bus.start = 1'b0; bus.sp = 1'b0;
    check("idle_start_state", bus.state_dbg, CAN_IDLE);
    check("idle_start_busy", bus.busy, 1'b0);

    run_frame(mk(11'h5A5, 18'h0F0F0, 1'b1, 1'b0), 1'b0, none, 1'b0, 1'b1, -1, "load_mid");
    run_frame(mk(11'h2C3, '0, 1'b0, 1'b1), 1'b0, none, 1'b1, 1'b0, -1, "start_sp");
    run_frame(mk(11'h6E1, 18'h12345, 1'b1, 1'b0), 1'b0, none, 1'b0, 1'b0, 5, "abort");
    run_frame(mk(11'h0F1, '0, 1'b0, 1'b0), 1'b0, none, 1'b0, 1'b0, -1, "fresh");

    for (int n = 0; n < 24; n++) begin
      me = mk(BASE_W'($urandom), EXT_W'($urandom), 1'($urandom), 1'($urandom));
      other.base = ($urandom_range(0, 1) == 0) ? me.base : BASE_W'($urandom);
      other.ext  = ($urandom_range(0, 1) == 0) ? me.ext : EXT_W'($urandom);
      other.ide  = LOSS_EN ? 1'($urandom) : me.ide;
      other.rtr  = 1'($urandom);
      run_frame(me, $urandom_range(0, 2) != 0, other, 1'($urandom), 1'b0, -1,
                $sformatf("rnd%0d", n));
    end

    repeat (4) tick();
    check("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
